dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the pipelined RV32I core: the memory end of the core's
//  load/store interface. Accepts one load/store request per handshake, performs byte/half/word
//  lane alignment and sign/zero extension, and returns a single-cycle response after a fixed latency.
//  Also exposes a combinational debug read port that feeds the seven-segment display mux.
// PARAMETERS
//  DEPTH_WORDS  64  number of 32-bit words; power of two; ADDR_W = $clog2(DEPTH_WORDS)
//  LATENCY      1   cycles from the accepting edge to the response; legal range 1..7
// PORTS
//  clk         in   1       system clock; all state on rising edge
//  rst         in   1       asynchronous reset, active-high
//  req_valid   in   1       request present
//  req_ready   out  1       responder can accept; high only in IDLE
//  req_we      in   1       1 = store, 0 = load
//  req_funct3  in   3       RV32I funct3 of the load/store
//  req_addr    in   32      byte address
//  req_wdata   in   32      store data, right-justified (rs2 value)
//  rsp_valid   out  1       one-cycle response strobe
//  rsp_rdata   out  32      load result, extended; 0 for stores and errors
//  rsp_err     out  1       misaligned or illegal funct3; qualified by rsp_valid
//  dbg_addr    in   ADDR_W  debug word index
//  dbg_data    out  32      combinational read of word dbg_addr
// BEHAVIOUR
//  - Reset: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0; req_ready=1 while in IDLE.
//    Memory array is not cleared by reset.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. Accept on rising edge with req_valid & req_ready; latch
//    we/funct3/addr/wdata; load counter with LATENCY-1. LATENCY=1: go straight to RESP.
//  - WAIT: decrement counter each cycle; at 0 take the RESP transition on the next edge.
//  - Commit happens on the edge entering RESP: store writes enabled lanes; load captures the
//    extended word into rsp_rdata. RESP lasts exactly one cycle with rsp_valid=1.
//  - Latency: rsp_valid is high LATENCY cycles after the request cycle. req_ready=0 in WAIT and
//    RESP; max throughput one request per LATENCY+1 cycles. Requests outside IDLE are ignored.
//  - Word index = addr[ADDR_W+1:2]; upper address bits are ignored (wrap modulo DEPTH_WORDS*4).
//  - Loads: LB(0) sign-extend byte addr[1:0]; LH(1) sign-extend half addr[1]; LW(2) word;
//    LBU(4)/LHU(5) zero-extend. Stores: SB(0) byte lane addr[1:0] <= wdata[7:0];
//    SH(1) half lane addr[1] <= wdata[15:0]; SW(2) full word.
//  - Error: half with addr[0]=1, word with addr[1:0]!=0, load funct3 in {3,6,7}, store
//    funct3 > 2 -> rsp_err=1, rsp_rdata=0, no memory write.
//  - rsp_rdata/rsp_err hold their values after RESP until the next response; rsp_valid=0.
//  - Reset mid-operation: in-flight transaction dropped, no write if RESP not yet entered, no response.
//  - dbg_data reflects the array combinationally, including a store committed on the previous edge.
// STRUCTURE
//  - defines.v gets: funct3 constants (LB/LH/LW/LBU/LHU, SB/SH/SW) and FSM state encodings
//    DMEM_IDLE/DMEM_WAIT/DMEM_RESP (2-bit).
//  - Sub-module dmem_lane_align: combinational; from funct3, addr[1:0], wdata and read word
//    produces 4-bit byte enable, aligned write word, extended load data and err.
//  - Top holds FSM, latency counter, request latches and the word array.
// TESTING
//  1. LATENCY=2: SW 0x12345678 @0x8 -> rsp_valid 2 cycles after request, err=0; LW @0x8 -> 0x12345678.
//  2. SB 0xAB @0x9 -> LB @0x9 = 0xFFFFFFAB; LBU @0x9 = 0x000000AB; LW @0x8 = 0x1234AB78.
//  3. SH 0x8001 @0xA -> LH @0xA = 0xFFFF8001; LHU @0xA = 0x00008001; LW @0x8 = 0x8001AB78.
//  4. LW @0x6 -> rsp_err=1, rdata=0; SH @0x3 -> err=1, dbg_addr=0 unchanged; funct3=3 load -> err=1.
//  5. req_valid held high for 12 cycles, LATENCY=2 -> accepts exactly every 3 cycles; one rsp each.
//  6. rst pulse during WAIT of SW 0xDEADBEEF @0x0 -> no rsp_valid, word 0 unchanged, req_ready=1
//     after reset; SW @DEPTH_WORDS*4 then dbg_addr=0 -> stored value (wrap).

Source files
------------

// File: rtl/dmem_responder_pkg.sv
//==============================================================================
// dmem_responder_pkg : funct3 encodings and FSM states shared by the
//                      data-memory responder and its lane aligner.
// Revision: 1.0
//==============================================================================
`default_nettype none

package dmem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
//==============================================================================
// dmem_lane_align : byte-lane steering for stores, extraction and sign/zero
//                   extension for loads, misalignment / illegal funct3 detect.
// Revision: 1.0
//==============================================================================
`default_nettype none

module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign w_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    be_o    = 4'b0000;
    wword_o = wdata_i;
    rdata_o = 32'd0;
    err_o   = 1'b0;
    if (we_i) begin
      // Store data is replicated so the enabled lane always sees its bytes.
      case (funct3_i)
        F3_SB: begin
          be_o    = 4'b0001 << addr_lo_i;
          wword_o = {4{wdata_i[7:0]}};
        end
        F3_SH: begin
          if (addr_lo_i[0]) begin
            err_o = 1'b1;
          end else begin
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wword_o = {2{wdata_i[15:0]}};
          end
        end
        F3_SW: begin
          if (addr_lo_i != 2'b00) err_o = 1'b1;
          else                    be_o  = 4'b1111;
        end
        default: err_o = 1'b1;
      endcase
    end else begin
      case (funct3_i)
        F3_LB:  rdata_o = {{24{w_byte[7]}}, w_byte};
        F3_LBU: rdata_o = {24'd0, w_byte};
        F3_LH: begin
          if (addr_lo_i[0]) err_o   = 1'b1;
          else              rdata_o = {{16{w_half[15]}}, w_half};
        end
        F3_LHU: begin
          if (addr_lo_i[0]) err_o   = 1'b1;
          else              rdata_o = {16'd0, w_half};
        end
        F3_LW: begin
          if (addr_lo_i != 2'b00) err_o   = 1'b1;
          else                    rdata_o = rword_i;
        end
        default: err_o = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
//==============================================================================
// dmem_responder : fixed-latency load/store responder with word array and a
//                  combinational debug read port.
// Revision: 1.0
//==============================================================================
`default_nettype none

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter  int DEPTH_WORDS = 64,
  parameter  int LATENCY     = 1,
  localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [31:0]       dbg_data_o
);

  dmem_state_e       state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              w_accept, w_commit, w_we, w_err;
  logic [2:0]        w_f3;
  logic [ADDR_W+1:0] w_addr;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_wdata, w_wword, w_rdata;
  logic [3:0]        w_be;
  logic              w_unused_addr;

  assign w_unused_addr = ^req_addr_i[31:ADDR_W+2];
  assign w_accept      = req_valid_i && (state_q == DMEM_IDLE);

  // With LATENCY=1 the commit edge is the accepting edge, so the live request is used.
  assign w_we    = (state_q == DMEM_IDLE) ? req_we_i                 : we_q;
  assign w_f3    = (state_q == DMEM_IDLE) ? req_funct3_i             : f3_q;
  assign w_addr  = (state_q == DMEM_IDLE) ? req_addr_i[ADDR_W+1:0]   : addr_q;
  assign w_wdata = (state_q == DMEM_IDLE) ? req_wdata_i              : wdata_q;
  assign w_idx   = w_addr[ADDR_W+1:2];

  dmem_lane_align u_align (
    .we_i      (w_we),
    .funct3_i  (w_f3),
    .addr_lo_i (w_addr[1:0]),
    .wdata_i   (w_wdata),
    .rword_i   (mem_q[w_idx]),
    .be_o      (w_be),
    .wword_o   (w_wword),
    .rdata_o   (w_rdata),
    .err_o     (w_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_IDLE: begin
        if (w_accept) begin
          cnt_d   = 3'(LATENCY - 1);
          state_d = (LATENCY == 1) ? DMEM_RESP : DMEM_WAIT;
        end
      end
      DMEM_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = DMEM_RESP;
      end
      DMEM_RESP: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  assign w_commit = (state_d == DMEM_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        addr_q  <= req_addr_i[ADDR_W+1:0];
        wdata_q <= req_wdata_i;
      end
      if (w_commit) begin
        rdata_q <= w_rdata;
        err_q   <= w_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_commit && w_we && w_be[i]) mem_q[w_idx][i*8 +: 8] <= w_wword[i*8 +: 8];
    end
  end

  assign req_ready_o = (state_q == DMEM_IDLE);
  assign rsp_valid_o = (state_q == DMEM_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign dbg_data_o  = mem_q[dbg_addr_i];

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//==============================================================================
// tb_dmem_responder : directed-vector bench for dmem_responder, LATENCY=2.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int DEPTH_WORDS = 64;
  localparam int LATENCY     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  dbg_addr = 6'd0;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .dbg_addr_i   (dbg_addr),
    .dbg_data_o   (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(LATENCY));
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  logic [11:0] acc_mask, rsp_mask;
  logic        seen;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err",   32'(rsp_err), 32'd0);

    do_req("sw8", 1'b1, 3'd2, 32'h8, 32'h12345678, rd, er);
    check("sw8_err", 32'(er), 32'd0);
    do_req("lw8a", 1'b0, 3'd2, 32'h8, 32'h0, rd, er);
    check("lw8a_data", rd, 32'h12345678);
    repeat (3) @(negedge clk);
    check("hold_data",  rsp_rdata, 32'h12345678);
    check("hold_valid", 32'(rsp_valid), 32'd0);

    do_req("sb9", 1'b1, 3'd0, 32'h9, 32'hFFFF_FFAB, rd, er);
    check("sb9_rdata", rd, 32'd0);
    do_req("lb9", 1'b0, 3'd0, 32'h9, 32'h0, rd, er);
    check("lb9_data", rd, 32'hFFFFFFAB);
    do_req("lbu9", 1'b0, 3'd4, 32'h9, 32'h0, rd, er);
    check("lbu9_data", rd, 32'h000000AB);
    do_req("lw8b", 1'b0, 3'd2, 32'h8, 32'h0, rd, er);
    check("lw8b_data", rd, 32'h1234AB78);

    do_req("sha", 1'b1, 3'd1, 32'hA, 32'h5555_8001, rd, er);
    do_req("lha", 1'b0, 3'd1, 32'hA, 32'h0, rd, er);
    check("lha_data", rd, 32'hFFFF8001);
    do_req("lhua", 1'b0, 3'd5, 32'hA, 32'h0, rd, er);
    check("lhua_data", rd, 32'h00008001);
    do_req("lw8c", 1'b0, 3'd2, 32'h8, 32'h0, rd, er);
    check("lw8c_data", rd, 32'h8001AB78);

    do_req("sw0", 1'b1, 3'd2, 32'h0, 32'h11223344, rd, er);
    do_req("lw6", 1'b0, 3'd2, 32'h6, 32'h0, rd, er);
    check("lw6_err",  32'(er), 32'd1);
    check("lw6_data", rd, 32'd0);
    do_req("sh3", 1'b1, 3'd1, 32'h3, 32'hFFFF_FFFF, rd, er);
    check("sh3_err", 32'(er), 32'd1);
    dbg_addr = 6'd0;
    #1 check("sh3_word0", dbg_data, 32'h11223344);
    do_req("ld3", 1'b0, 3'd3, 32'h8, 32'h0, rd, er);
    check("ld3_err",  32'(er), 32'd1);
    check("ld3_data", rd, 32'd0);
    do_req("st4", 1'b1, 3'd4, 32'h8, 32'hFFFF_FFFF, rd, er);
    check("st4_err", 32'(er), 32'd1);
    dbg_addr = 6'd2;
    #1 check("st4_word2", dbg_data, 32'h8001AB78);

    // Back-to-back: valid held for 12 cycles, expect acceptance every third cycle.
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h8; req_valid = 1'b1;
    acc_mask = '0; rsp_mask = '0;
    for (int k = 0; k < 12; k++) begin
      acc_mask[k] = req_ready;
      rsp_mask[k] = rsp_valid;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_accept", 32'(acc_mask), 32'h249);
    check("b2b_resp",   32'(rsp_mask), 32'h924);
    check("b2b_data",   rsp_rdata, 32'h8001AB78);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    check("b2b_extra", 32'(seen), 32'd0);

    // Reset while a store waits for its commit edge.
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h0; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      seen |= rsp_valid;
      @(negedge clk);
    end
    check("rstw_noresp", 32'(seen), 32'd0);
    check("rstw_ready",  32'(req_ready), 32'd1);
    check("rstw_rdata",  rsp_rdata, 32'd0);
    dbg_addr = 6'd0;
    #1 check("rstw_word0", dbg_data, 32'h11223344);

    do_req("swwrap", 1'b1, 3'd2, 32'(DEPTH_WORDS * 4), 32'hCAFEF00D, rd, er);
    check("swwrap_err", 32'(er), 32'd0);
    dbg_addr = 6'd0;
    #1 check("swwrap_dbg", dbg_data, 32'hCAFEF00D);
    do_req("lwwrap", 1'b0, 3'd2, 32'h0, 32'h0, rd, er);
    check("lwwrap_data", rd, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
